// File: rtl/axil_pwm_pkg.sv
// axil_pwm_pkg: shared offsets, response codes, FSM states and
// helpers for the AXI4-Lite PWM register block.
package axil_pwm_pkg;

    localparam logic [7:0] OFF_VER     = 8'h00;
    localparam logic [7:0] OFF_DATE    = 8'h04;
    localparam logic [7:0] OFF_SCRATCH = 8'h08;
    localparam logic [7:0] OFF_CTRL    = 8'h0C;
    localparam logic [7:0] OFF_CAPS    = 8'h10;
    localparam logic [7:0] CH_BASE     = 8'h20;
    localparam logic [7:0] CH_STRIDE   = 8'h08;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        W_IDLE,
        W_GOTA,
        W_GOTD,
        W_RESP
    } wr_st_t;

    typedef enum logic {
        R_IDLE,
        R_DATA
    } rd_st_t;

    typedef enum logic [2:0] {
        K_NONE,
        K_VER,
        K_DATE,
        K_SCRATCH,
        K_CTRL,
        K_CAPS,
        K_DIV,
        K_DUTY
    } kind_t;

    function automatic logic [31:0] apply_wstrb(
        input logic [31:0] old,
        input logic [31:0] data,
        input logic [3:0]  strb
    );
        logic [31:0] r;
        r = old;
        for (int k = 0; k < 4; k++) begin
            if (strb[k]) r[8*k +: 8] = data[8*k +: 8];
        end
        return r;
    endfunction

    // Channel index of a word address inside the channel window
    function automatic logic [4:0] ch_of(input logic [5:0] w);
        return 5'(({w, 2'b00} - CH_BASE) / CH_STRIDE);
    endfunction

    // Classify a word address; hi_zero says all bits above [7:0] are 0
    function automatic kind_t decode(
        input logic [5:0] w,
        input logic       hi_zero,
        input int         n_ch
    );
        logic [7:0] off;
        kind_t      k;
        off = {w, 2'b00};
        k   = K_NONE;
        if (!hi_zero)                k = K_NONE;
        else if (off == OFF_VER)     k = K_VER;
        else if (off == OFF_DATE)    k = K_DATE;
        else if (off == OFF_SCRATCH) k = K_SCRATCH;
        else if (off == OFF_CTRL)    k = K_CTRL;
        else if (off == OFF_CAPS)    k = K_CAPS;
        else if (off >= CH_BASE && int'(ch_of(w)) < n_ch)
            k = w[0] ? K_DUTY : K_DIV;
        return k;
    endfunction

endpackage

// File: rtl/axil_pwm_ch_reg.sv
// axil_pwm_ch_reg: DIV/DUTY storage for one PWM channel; with
// AXIL_PWM_SHADOW_EN the outputs reload only on update_i.
module axil_pwm_ch_reg
    import axil_pwm_pkg::*;
#(
    parameter int PWM_W = 8
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             div_we_i,
    input  logic             duty_we_i,
    input  logic [31:0]      wdata_i,
    input  logic [3:0]       wstrb_i,
    input  logic             update_i,
    output logic [PWM_W-1:0] div_rd_o,
    output logic [PWM_W-1:0] duty_rd_o,
    output logic [PWM_W-1:0] pwm_div_o,
    output logic [PWM_W-1:0] pwm_duty_o
);

    logic [PWM_W-1:0] div_q, div_d;
    logic [PWM_W-1:0] duty_q, duty_d;

    // Byte-lane merge of a committed write; narrow fields keep low bits
    always_comb begin
        div_d  = div_q;
        duty_d = duty_q;
        if (div_we_i)
            div_d = PWM_W'(apply_wstrb(32'(div_q), wdata_i, wstrb_i));
        if (duty_we_i)
            duty_d = PWM_W'(apply_wstrb(32'(duty_q), wdata_i, wstrb_i));
    end

    // Software-visible field registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            div_q  <= '0;
            duty_q <= '0;
        end else begin
            div_q  <= div_d;
            duty_q <= duty_d;
        end
    end

    assign div_rd_o  = div_q;
    assign duty_rd_o = duty_q;

`ifdef AXIL_PWM_SHADOW_EN
    logic [PWM_W-1:0] div_act_q, duty_act_q;

    // Active copies follow the visible ones only at a period boundary
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            div_act_q  <= '0;
            duty_act_q <= '0;
        end else if (update_i) begin
            div_act_q  <= div_q;
            duty_act_q <= duty_q;
        end
    end

    assign pwm_div_o  = div_act_q;
    assign pwm_duty_o = duty_act_q;
`else
    logic unused_update;
    assign unused_update = update_i;
    assign pwm_div_o  = div_q;
    assign pwm_duty_o = duty_q;
`endif

endmodule

// File: rtl/axil_pwm_regs.sv
// axil_pwm_regs: AXI4-Lite register file driving N_CH PWM channels.
// Define AXIL_PWM_SHADOW_EN to reload outputs only on pwm_update.
module axil_pwm_regs
    import axil_pwm_pkg::*;
#(
    parameter int          N_CH     = 4,
    parameter int          PWM_W    = 8,
    parameter int          C_DATA_W = 32,
    parameter int          C_ADDR_W = 32,
    parameter logic [31:0] VERSION  = 32'h0000_0002,
    parameter logic [31:0] DATE     = 32'h2110_0922
) (
    input  logic                  s_axi_aclk,
    input  logic                  s_axi_aresetn,
    input  logic [C_ADDR_W-1:0]   s_axi_awaddr,
    input  logic                  s_axi_awvalid,
    output logic                  s_axi_awready,
    input  logic [C_DATA_W-1:0]   s_axi_wdata,
    input  logic [C_DATA_W/8-1:0] s_axi_wstrb,
    input  logic                  s_axi_wvalid,
    output logic                  s_axi_wready,
    output logic [1:0]            s_axi_bresp,
    output logic                  s_axi_bvalid,
    input  logic                  s_axi_bready,
    input  logic [C_ADDR_W-1:0]   s_axi_araddr,
    input  logic                  s_axi_arvalid,
    output logic                  s_axi_arready,
    output logic [C_DATA_W-1:0]   s_axi_rdata,
    output logic [1:0]            s_axi_rresp,
    output logic                  s_axi_rvalid,
    input  logic                  s_axi_rready,
    input  logic                  pwm_update,
    output logic [N_CH-1:0]       pwm_en,
    output logic [N_CH*PWM_W-1:0] pwm_div,
    output logic [N_CH*PWM_W-1:0] pwm_duty
);

    if (C_DATA_W != 32 || N_CH < 1 || N_CH > 16 ||
        PWM_W < 1 || PWM_W > 32 || C_ADDR_W < 8) begin : g_bad_cfg
        $error("axil_pwm_regs: unsupported parameter set");
    end

    wr_st_t              wr_st_q;
    logic                awready_q, wready_q, bvalid_q;
    logic [1:0]          bresp_q;
    logic [C_ADDR_W-1:0] awaddr_q;
    logic [31:0]         wdata_q;
    logic [3:0]          wstrb_q;
    logic [31:0]         scratch_q;
    logic [N_CH-1:0]     ctrl_q;

    logic                aw_hs, w_hs, wr_commit, wr_ok;
    logic [C_ADDR_W-1:0] w_addr;
    logic [31:0]         w_data;
    logic [3:0]          w_strb;
    kind_t               w_kind;
    logic [4:0]          w_ch;
    logic [1:0]          w_resp;

    assign aw_hs  = s_axi_awvalid & awready_q;
    assign w_hs   = s_axi_wvalid & wready_q;
    assign w_addr = (wr_st_q == W_GOTA) ? awaddr_q : s_axi_awaddr;
    assign w_data = (wr_st_q == W_GOTD) ? wdata_q : s_axi_wdata;
    assign w_strb = (wr_st_q == W_GOTD) ? wstrb_q : s_axi_wstrb;
    assign w_kind = decode(w_addr[7:2], (w_addr >> 8) == '0, N_CH);
    assign w_ch   = ch_of(w_addr[7:2]);
    assign w_resp = (w_kind inside {K_SCRATCH, K_CTRL, K_DIV, K_DUTY})
                  ? RESP_OKAY : RESP_SLVERR;

    assign wr_commit = ((wr_st_q == W_IDLE) & aw_hs & w_hs)
                     | ((wr_st_q == W_GOTA) & w_hs)
                     | ((wr_st_q == W_GOTD) & aw_hs);
    assign wr_ok     = wr_commit & (w_resp == RESP_OKAY);

    // Write channel FSM: AW and W accepted independently, one response
    always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
        if (!s_axi_aresetn) begin
            wr_st_q   <= W_IDLE;
            awready_q <= 1'b1;
            wready_q  <= 1'b1;
            bvalid_q  <= 1'b0;
            bresp_q   <= RESP_OKAY;
            awaddr_q  <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
        end else begin
            unique case (wr_st_q)
                W_IDLE, W_GOTA, W_GOTD: begin
                    if (wr_commit) begin
                        awready_q <= 1'b0;
                        wready_q  <= 1'b0;
                        bvalid_q  <= 1'b1;
                        bresp_q   <= w_resp;
                        wr_st_q   <= W_RESP;
                    end else if (wr_st_q == W_IDLE && aw_hs) begin
                        awaddr_q  <= s_axi_awaddr;
                        awready_q <= 1'b0;
                        wr_st_q   <= W_GOTA;
                    end else if (wr_st_q == W_IDLE && w_hs) begin
                        wdata_q  <= s_axi_wdata;
                        wstrb_q  <= s_axi_wstrb;
                        wready_q <= 1'b0;
                        wr_st_q  <= W_GOTD;
                    end
                end
                W_RESP: begin
                    if (s_axi_bready) begin
                        bvalid_q  <= 1'b0;
                        awready_q <= 1'b1;
                        wready_q  <= 1'b1;
                        wr_st_q   <= W_IDLE;
                    end
                end
                default: wr_st_q <= W_IDLE;
            endcase
        end
    end

    // SCRATCH and CTRL update on the edge that enters W_RESP
    always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
        if (!s_axi_aresetn) begin
            scratch_q <= '0;
            ctrl_q    <= '0;
        end else begin
            if (wr_ok && w_kind == K_SCRATCH)
                scratch_q <= apply_wstrb(scratch_q, w_data, w_strb);
            if (wr_ok && w_kind == K_CTRL)
                ctrl_q <= N_CH'(apply_wstrb(32'(ctrl_q), w_data, w_strb));
        end
    end

    logic [N_CH-1:0][PWM_W-1:0] div_rd, duty_rd;

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        axil_pwm_ch_reg #(.PWM_W(PWM_W)) u_ch (
            .clk_i      (s_axi_aclk),
            .rst_ni     (s_axi_aresetn),
            .div_we_i   (wr_ok && w_kind == K_DIV && w_ch == 5'(i)),
            .duty_we_i  (wr_ok && w_kind == K_DUTY && w_ch == 5'(i)),
            .wdata_i    (w_data),
            .wstrb_i    (w_strb),
            .update_i   (pwm_update),
            .div_rd_o   (div_rd[i]),
            .duty_rd_o  (duty_rd[i]),
            .pwm_div_o  (pwm_div[i*PWM_W +: PWM_W]),
            .pwm_duty_o (pwm_duty[i*PWM_W +: PWM_W])
        );
    end

`ifdef AXIL_PWM_SHADOW_EN
    logic [N_CH-1:0] en_act_q;

    // Enable mask takes the CTRL value only at a period boundary
    always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
        if (!s_axi_aresetn)  en_act_q <= '0;
        else if (pwm_update) en_act_q <= ctrl_q;
    end

    assign pwm_en = en_act_q;
`else
    assign pwm_en = ctrl_q;
`endif

    rd_st_t      rd_st_q;
    logic        arready_q, rvalid_q;
    logic [1:0]  rresp_q;
    logic [31:0] rdata_q, r_data;
    kind_t       r_kind;
    logic [4:0]  r_ch;

    assign r_kind = decode(s_axi_araddr[7:2], (s_axi_araddr >> 8) == '0, N_CH);
    assign r_ch   = ch_of(s_axi_araddr[7:2]);

    // Read mux over current values, so a same-edge write is not seen
    always_comb begin
        r_data = '0;
        unique case (r_kind)
            K_VER:     r_data = VERSION;
            K_DATE:    r_data = DATE;
            K_SCRATCH: r_data = scratch_q;
            K_CTRL:    r_data = 32'(ctrl_q);
            K_CAPS:    r_data = {16'h0, 8'(PWM_W), 8'(N_CH)};
            K_DIV:
                for (int i = 0; i < N_CH; i++)
                    if (r_ch == 5'(i)) r_data = 32'(div_rd[i]);
            K_DUTY:
                for (int i = 0; i < N_CH; i++)
                    if (r_ch == 5'(i)) r_data = 32'(duty_rd[i]);
            default:   r_data = '0;
        endcase
    end

    // Read channel FSM: data and response registered with the AR handshake
    always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
        if (!s_axi_aresetn) begin
            rd_st_q   <= R_IDLE;
            arready_q <= 1'b1;
            rvalid_q  <= 1'b0;
            rdata_q   <= '0;
            rresp_q   <= RESP_OKAY;
        end else begin
            unique case (rd_st_q)
                R_IDLE: begin
                    if (s_axi_arvalid && arready_q) begin
                        rdata_q   <= r_data;
                        rresp_q   <= (r_kind == K_NONE) ? RESP_SLVERR : RESP_OKAY;
                        arready_q <= 1'b0;
                        rvalid_q  <= 1'b1;
                        rd_st_q   <= R_DATA;
                    end
                end
                R_DATA: begin
                    if (s_axi_rready) begin
                        rvalid_q  <= 1'b0;
                        arready_q <= 1'b1;
                        rd_st_q   <= R_IDLE;
                    end
                end
                default: rd_st_q <= R_IDLE;
            endcase
        end
    end

    logic unused_lsb;
    assign unused_lsb = ^{s_axi_araddr[1:0], w_addr[1:0]};

    assign s_axi_awready = awready_q;
    assign s_axi_wready  = wready_q;
    assign s_axi_bvalid  = bvalid_q;
    assign s_axi_bresp   = bresp_q;
    assign s_axi_arready = arready_q;
    assign s_axi_rvalid  = rvalid_q;
    assign s_axi_rdata   = rdata_q;
    assign s_axi_rresp   = rresp_q;

endmodule
